divisor_mantisa: RTL and testbench

- Sequential radix-2 restoring divider for 24-bit floating-point mantissas; the inverse operation of the team's combinational mantissa multiplier.
- Same operand and result widths as the multiplier: in1/in2 are 24-bit mantissas (hidden bit included), out is a 32-bit fixed-point quotient.
- Produces one quotient bit per clock behind a start/busy/done handshake.
- Feeds the FP division datapath; exponent handling and normalisation are done downstream.

---
 rtl/fp_pkg.sv | 8 +
 rtl/div_step.sv | 19 +
 rtl/divisor_mantisa.sv | 76 +++++++
 tb/tb_divisor_mantisa.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared mantissa/quotient widths, divider state encoding and saturation value.
package fp_pkg;
    localparam int MW = 24;
    localparam int QW = 32;
    localparam int QF = 31;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [QW-1:0] SAT = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in a dividend bit, trial-subtract the divisor).
module div_step #(
    parameter int WI = 24
) (
    input  logic [WI:0]   rem,
    input  logic          b,
    input  logic [WI-1:0] dv,
    output logic [WI:0]   nrem,
    output logic          q
);
    logic [WI+1:0] t, d;
    // rem < dv keeps t below 2^(WI+1), so the top bit of d is the borrow
    always_comb begin
        t = {rem, b};
        d = t - {2'b0, dv};
        q = ~d[WI+1];
        nrem = q ? d[WI:0] : t[WI:0];
    end
endmodule

// File: rtl/divisor_mantisa.sv
// divisor_mantisa: sequential radix-2 restoring mantissa divider, out = floor(in1*2^FRAC/in2).
module divisor_mantisa
    import fp_pkg::*;
#(
    parameter int WI   = MW,
    parameter int WO   = QW,
    parameter int FRAC = QF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WI-1:0] in1,
    input  logic [WI-1:0] in2,
    output logic          busy,
    output logic          done,
    output logic [WO-1:0] out,
    output logic          dz,
    output logic          ovf
);
    localparam int SH = WO - FRAC;
    localparam int WX = WI + SH;
    localparam int CW = $clog2(WO);
    state_t state, nxt;
    logic [WI:0] rem, nrem;
    logic [WI-1:0] dvs;
    logic [WO-1:0] acc;
    logic [CW-1:0] cnt;
    logic qb, zero, big, sat;
    assign zero = in2 == '0;
    assign big = WX'(in1) >= (WX'(in2) << SH);
    assign sat = zero | big;
    // acc shifts dividend bits out of the top while quotient bits enter at the bottom
    div_step #(.WI(WI)) u_step (
        .rem (rem),
        .b   (acc[WO-1]),
        .dv  (dvs),
        .nrem(nrem),
        .q   (qb)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state == IDLE ? (start ? (sat ? DONE : RUN) : IDLE) :
              state == RUN  ? (cnt == '0 ? DONE : RUN) : IDLE;
    end
    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            dvs <= '0;
            acc <= '0;
            cnt <= '0;
            out <= '0;
            dz  <= 1'b0;
            ovf <= 1'b0;
        end else if (state == IDLE && start) begin
            rem <= (WI+1)'(in1 >> SH);
            dvs <= in2;
            acc <= WO'(in1) << FRAC;
            cnt <= CW'(WO - 1);
            dz  <= zero;
            ovf <= ~zero & big;
            if (sat) out <= WO'(SAT);
        end else if (state == RUN) begin
            rem <= nrem;
            acc <= {acc[WO-2:0], qb};
            cnt <= cnt - 1'b1;
            if (cnt == '0) out <= {acc[WO-2:0], qb};
        end
    end
endmodule

// File: tb/tb_divisor_mantisa.sv
// tb_divisor_mantisa: directed table, handshake corner cases and random normalised vectors.
module tb_divisor_mantisa;
    logic clk = 0, rst = 1, start = 0;
    logic [23:0] in1 = 0, in2 = 0;
    logic busy, done, dz, ovf;
    logic [31:0] out;
    int total = 0, bad = 0;

    divisor_mantisa dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .out(out), .dz(dz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] a, b;
        logic [31:0] q;
        logic z, v;
        int lat;
    } vec_t;
    vec_t tv[11];

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    task automatic wait_done(input int c0, output int lat);
        int c = c0;
        while (!done && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        lat = c + 1;
    endtask

    // start edge to the edge ending the done cycle; returns with the DUT back in IDLE
    task automatic do_op(input logic [23:0] a, input logic [23:0] b,
                         output logic [31:0] q, output logic z, output logic v, output int lat);
        @(negedge clk);
        in1 = a;
        in2 = b;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        wait_done(0, lat);
        q = out;
        z = dz;
        v = ovf;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] q;
        logic z, v;
        int lat;
        logic [23:0] a, b;
        logic [63:0] e;
        tv[0]  = '{24'h0B696D, 24'h0B696D, 32'h80000000, 0, 0, 33};
        tv[1]  = '{24'hC00000, 24'h800000, 32'hC0000000, 0, 0, 33};
        tv[2]  = '{24'h800000, 24'hC00000, 32'h55555555, 0, 0, 33};
        tv[3]  = '{24'h800000, 24'h000000, 32'hFFFFFFFF, 1, 0, 1};
        tv[4]  = '{24'h800000, 24'h400000, 32'hFFFFFFFF, 0, 1, 1};
        tv[5]  = '{24'h7FFFFF, 24'h400000, 32'hFFFFFE00, 0, 0, 33};
        tv[6]  = '{24'h000000, 24'h000001, 32'h00000000, 0, 0, 33};
        tv[7]  = '{24'h000001, 24'hFFFFFF, 32'h00000080, 0, 0, 33};
        tv[8]  = '{24'hFFFFFF, 24'hFFFFFF, 32'h80000000, 0, 0, 33};
        tv[9]  = '{24'h000002, 24'h000001, 32'hFFFFFFFF, 0, 1, 1};
        tv[10] = '{24'h000001, 24'h000001, 32'h80000000, 0, 0, 33};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out", out, 0);
        chk("rst_dz", dz, 0);
        chk("rst_ovf", ovf, 0);

        for (int i = 0; i < 11; i++) begin
            do_op(tv[i].a, tv[i].b, q, z, v, lat);
            chk($sformatf("vec%0d_out", i), q, tv[i].q);
            chk($sformatf("vec%0d_dz", i), z, tv[i].z);
            chk($sformatf("vec%0d_ovf", i), v, tv[i].v);
            chk($sformatf("vec%0d_lat", i), lat, tv[i].lat);
        end

        // start during RUN is ignored and out holds the previous result
        @(negedge clk);
        in1 = 24'hC00000;
        in2 = 24'h800000;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (10) @(posedge clk);
        #1;
        in1 = 24'h123456;
        in2 = 24'h000001;
        start = 1;
        chk("ign_busy", busy, 1);
        chk("ign_out_hold", out, 32'h80000000);
        @(posedge clk);
        #1;
        in1 = 24'h800000;
        in2 = 24'hC00000;
        wait_done(11, lat);
        chk("ign_out", out, 32'hC0000000);
        chk("ign_lat", lat, 33);
        // start still high: re-accepted in the IDLE cycle after DONE
        @(posedge clk);
        #1;
        chk("b2b_idle", busy, 0);
        @(posedge clk);
        #1;
        start = 0;
        chk("b2b_busy", busy, 1);
        wait_done(0, lat);
        chk("b2b_out", out, 32'h55555555);
        chk("b2b_lat", lat, 33);
        @(posedge clk);

        // asynchronous reset mid-RUN
        @(negedge clk);
        in1 = 24'hC00000;
        in2 = 24'h800000;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (15) @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_out", out, 0);
        chk("arst_dz", dz, 0);
        chk("arst_ovf", ovf, 0);
        @(negedge clk);
        rst = 0;
        do_op(24'h800000, 24'hC00000, q, z, v, lat);
        chk("arst_after_out", q, 32'h55555555);
        chk("arst_after_lat", lat, 33);

        for (int i = 0; i < 1000; i++) begin
            a = {1'b1, 23'($urandom)};
            b = {1'b1, 23'($urandom)};
            e = ({40'b0, a} << 31) / {40'b0, b};
            do_op(a, b, q, z, v, lat);
            chk($sformatf("rnd%0d_out", i), q, e[31:0]);
            chk($sformatf("rnd%0d_lat", i), lat, 33);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
